// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, control encodings and the
// decoded control bundle carried from stage to stage.
package pipe_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic {
    RES_ALU = 1'b0,
    RES_MEM = 1'b1
  } result_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       result_src;
    logic       alu_src;
    logic       branch;
    logic [2:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // A bundle that belongs to no real instruction must never write state.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : CTRL_NOP;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the instruction in E is a load whose destination
// is read by the instruction in D, so D must wait one cycle.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             valid_e,
  input  logic             reg_write_e,
  input  logic             result_src_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic             valid_d,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  output logic             lu
);

  logic load_in_e;

  // x0 is never a real producer, so a load to x0 creates no dependency.
  assign load_in_e = valid_e & reg_write_e & (result_src_e == RES_MEM) & (rd_e != '0);

  // rs2 is compared even for formats without rs2: a rare spurious stall is cheaper
  // than decoding the format here.
  assign lu = load_in_e & valid_d & ((rd_e == rs1_d) | (rd_e == rs2_d));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// external hold and a saturating count of inserted bubbles.
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int XLEN  = pipe_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_d,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ResultSrcD,
  input  logic             ALUSrcD,
  input  logic             BranchD,
  input  logic [2:0]       ALUControlD,
  input  logic [XLEN-1:0]  RD1_D,
  input  logic [XLEN-1:0]  RD2_D,
  input  logic [XLEN-1:0]  Imm_Ext_D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [REG_W-1:0] RS1_D,
  input  logic [REG_W-1:0] RS2_D,
  input  logic [REG_W-1:0] RD_D,
  input  logic             flush_e,
  input  logic             hold,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             ResultSrcE,
  output logic             ALUSrcE,
  output logic             BranchE,
  output logic [2:0]       ALUControlE,
  output logic [XLEN-1:0]  RD1_E,
  output logic [XLEN-1:0]  RD2_E,
  output logic [XLEN-1:0]  Imm_Ext_E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [REG_W-1:0] RS1_E,
  output logic [REG_W-1:0] RS2_E,
  output logic [REG_W-1:0] RD_E,
  output logic             valid_e,
  output logic             stall_fd,
  output logic [CNT_W-1:0] bubble_cnt
);

  ctrl_t            ctrl_d;
  ctrl_t            ctrl_q;
  logic             valid_q;
  logic [XLEN-1:0]  rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [REG_W-1:0] rs1_q, rs2_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lu;
  logic             bubble;

  // NOTE: every field is given a value before the gate, so no latch is inferred.
  always_comb begin
    ctrl_d             = CTRL_NOP;
    ctrl_d.reg_write   = RegWriteD;
    ctrl_d.mem_write   = MemWriteD;
    ctrl_d.result_src  = ResultSrcD;
    ctrl_d.alu_src     = ALUSrcD;
    ctrl_d.branch      = BranchD;
    ctrl_d.alu_control = ALUControlD;
    ctrl_d             = gate_ctrl(ctrl_d, valid_d);
  end

  load_use_detect u_lu (
    .valid_e      (valid_q),
    .reg_write_e  (ctrl_q.reg_write),
    .result_src_e (ctrl_q.result_src),
    .rd_e         (rd_q),
    .valid_d      (valid_d),
    .rs1_d        (RS1_D),
    .rs2_d        (RS2_D),
    .lu           (lu)
  );

  // A flush replaces D anyway, so fetch/decode must not be frozen by it.
  assign stall_fd = (lu | hold) & ~flush_e;
  assign bubble   = lu & ~hold & ~flush_e;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (flush_e) begin
      ctrl_q  <= CTRL_NOP;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
    end else if (!hold) begin
      if (lu) begin
        // Bubble: data fields are left as-is, they are dead while valid is low.
        ctrl_q  <= CTRL_NOP;
        valid_q <= 1'b0;
      end else begin
        ctrl_q  <= ctrl_d;
        valid_q <= valid_d;
        rd1_q   <= RD1_D;
        rd2_q   <= RD2_D;
        imm_q   <= Imm_Ext_D;
        pc_q    <= PCD;
        pc4_q   <= PCPlus4D;
        rs1_q   <= RS1_D;
        rs2_q   <= RS2_D;
        rd_q    <= RD_D;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (bubble && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign BranchE     = ctrl_q.branch;
  assign ALUControlE = ctrl_q.alu_control;
  assign RD1_E       = rd1_q;
  assign RD2_E       = rd2_q;
  assign Imm_Ext_E   = imm_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc4_q;
  assign RS1_E       = rs1_q;
  assign RS2_E       = rs2_q;
  assign RD_E        = rd_q;
  assign valid_e     = valid_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the control unit and register-file read.
- Captures the decoded control bundle (RegWrite, MemWrite, ResultSrc, ALUSrc, Branch, ALUControl) and the operand/PC data into the E stage.
- Detects load-use hazards, inserts bubbles and back-pressures fetch/decode.
- Applies branch flush and external hold, and counts inserted bubbles for performance monitoring.

Parameters:
- XLEN, 32, data/PC width.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- valid_d  in  1  D-stage holds a real instruction.
- RegWriteD, MemWriteD, ResultSrcD, ALUSrcD, BranchD  in  1 each  decoded control; ResultSrcD=1 means load.
- ALUControlD  in  3  ALU operation.
- RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D  in  XLEN each  operands, immediate, PC values.
- RS1_D, RS2_D, RD_D  in  5 each  register indices.
- flush_e  in  1  branch taken in E; kill D→E transfer.
- hold  in  1  external stall (downstream busy); freeze E.
- RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE  out  1 each  registered control.
- ALUControlE  out  3  registered ALU op.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN each  registered data.
- RS1_E, RS2_E, RD_E  out  5 each  registered indices, for forwarding.
- valid_e  out  1  E holds a real instruction.
- stall_fd  out  1  combinational; freeze PC and IF/ID register.
- bubble_cnt  out  CNT_W  bubbles inserted since reset, saturating.

Behaviour:
- Reset (rst=0, asynchronous): every registered output, including valid_e and bubble_cnt, goes to 0 immediately. stall_fd is therefore 0 at reset.
- Reset mid-operation discards the E contents with no partial state.
- Load-use hazard (combinational):
  - lu = valid_e & ResultSrcE & RegWriteE & (RD_E!=0) & valid_d & ((RD_E==RS1_D) | (RD_E==RS2_D)).
  - The RS2 compare is always applied (conservative), even for instructions that do not read rs2.
- stall_fd = (lu | hold) & ~flush_e.
- Per-edge priority, highest first:
  - flush_e=1: all control outputs and valid_e cleared to 0. Data/index fields may load any value; they are don't-care once valid_e=0. Clearing them is preferred.
  - hold=1: all E outputs keep their value.
  - lu=1: bubble inserted, i.e. control and valid_e cleared. The D instruction stays in D because stall_fd=1, so it enters E on the next non-stalled edge, one cycle later.
  - Otherwise: all *_D values are captured into *_E; valid_e <= valid_d.
- Gating: when valid_d=0, the captured control signals are forced to 0 regardless of *_D inputs.
- Latency: 1 cycle D→E. A load followed by a dependent instruction gives exactly 1 bubble.
- bubble_cnt increments by 1 on each edge where a load-use bubble is inserted, i.e. case lu with no flush and no hold. It saturates at 2^CNT_W−1 and does not wrap. Flush does not count.
- Simultaneous lu and hold: hold wins; no bubble, no count. lu is re-evaluated next cycle.
- Simultaneous flush_e and hold: flush wins; E is cleared.

Decomposition:
- Shared package pipe_pkg:
  - XLEN and register-index width (5).
  - ResultSrc encoding (0=ALU, 1=mem).
  - ALUControl encodings: ADD=000, SUB=001, AND=010, OR=011, SLT=101.
  - A control-bundle struct/typedef reused by the EX/MEM stage register.
- One natural sub-module, load_use_detect: purely combinational, computes lu from E-stage fields and D-stage sources. It is reused later by the forwarding/hazard unit.

Test Plan:
- Reset: drive all *_D nonzero with valid_d=1, pulse rst=0 mid-cycle → all outputs are 0 asynchronously, before the next clk edge; bubble_cnt=0.
- Normal flow: ALUControlD=001, RD1_D=0x5, RD2_D=0x3, RD_D=7, valid_d=1 → after one edge ALUControlE=001, RD1_E=0x5, RD_E=7, valid_e=1, stall_fd=0.
- Load-use:
  - Stimulus: a load with RD_D=5, ResultSrcD=1, RegWriteD=1 enters E; the next D has RS1_D=5.
  - Required: stall_fd=1 for one cycle; next edge valid_e=0 and RegWriteE=0; bubble_cnt=1; the dependent instruction appears in E one edge later.
  - Repeat with RD_D=0 → no stall.
- Flush priority: flush_e=1 with hold=1 and lu=1 → next edge valid_e=0, all control 0, stall_fd=0, bubble_cnt unchanged.
- Hold: hold=1 for 3 cycles while *_D changes → E outputs frozen; stall_fd=1; on release, the current D values are captured.
- Saturation: CNT_W=2, force 5 consecutive load-use bubbles → bubble_cnt goes 1,2,3,3,3.
